// File: rtl/regfile_wb.sv
// regfile_wb: 32x32 register file with busy scoreboard; REGFILE_WB_BYPASS_EN enables same-cycle writeback bypass
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic              wb_write_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic              issue_wr_i,
    input  logic              flush_i
);
`ifdef REGFILE_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_hit1, w_hit2;

    // later assignments take priority: flush > issue set > writeback clear
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_write_i) w_busy_nxt[wb_addr_i] = 1'b0;
        if (issue_i && issue_wr_i) w_busy_nxt[issue_rd_i] = 1'b1;
        if (flush_i) w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (wb_write_i && wb_addr_i != '0) r_regs[wb_addr_i] <= wb_data_i;
            r_busy <= w_busy_nxt;
        end
    end

    assign w_hit1 = BYP && wb_write_i && wb_addr_i != '0 && wb_addr_i == rs1_addr_i;
    assign w_hit2 = BYP && wb_write_i && wb_addr_i != '0 && wb_addr_i == rs2_addr_i;

    // outputs are forced quiet while reset is held, so the bypass cannot leak wb_data_i
    assign rs1_data_o = (!rst || rs1_addr_i == '0) ? '0 : w_hit1 ? wb_data_i : r_regs[rs1_addr_i];
    assign rs2_data_o = (!rst || rs2_addr_i == '0) ? '0 : w_hit2 ? wb_data_i : r_regs[rs2_addr_i];
    assign rs1_busy_o = rst && !w_hit1 && r_busy[rs1_addr_i];
    assign rs2_busy_o = rst && !w_hit2 && r_busy[rs2_addr_i];
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed bench for regfile_wb with an array-based reference model
module tb_regfile_wb;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_addr_i, rs1_addr_i, rs2_addr_i, issue_rd_i;
    logic        wb_write_i, issue_i, issue_wr_i, flush_i;
    logic [31:0] wb_data_i, rs1_data_o, rs2_data_o;
    logic        rs1_busy_o, rs2_busy_o;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_wb dut (
        .clk(clk), .rst(rst),
        .wb_addr_i(wb_addr_i), .wb_write_i(wb_write_i), .wb_data_i(wb_data_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .issue_i(issue_i), .issue_rd_i(issue_rd_i), .issue_wr_i(issue_wr_i),
        .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: register contents and busy flags from the stated rules
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'h0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (wb_write_i && wb_addr_i != 0) m_regs[wb_addr_i] <= wb_data_i;
            for (int i = 1; i < 32; i++)
                m_busy[i] <= flush_i ? 1'b0 :
                             (issue_i && issue_wr_i && issue_rd_i == i) ? 1'b1 :
                             (wb_write_i && wb_addr_i == i) ? 1'b0 : m_busy[i];
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!rst || a == 0) return 32'h0;
        if (BYP && wb_write_i && wb_addr_i == a) return wb_data_i;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!rst || a == 0) return 1'b0;
        if (BYP && wb_write_i && wb_addr_i == a) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        chk("model rs1_data", rs1_data_o, exp_data(rs1_addr_i));
        chk("model rs2_data", rs2_data_o, exp_data(rs2_addr_i));
        chk("model rs1_busy", {31'h0, rs1_busy_o}, {31'h0, exp_busy(rs1_addr_i)});
        chk("model rs2_busy", {31'h0, rs2_busy_o}, {31'h0, exp_busy(rs2_addr_i)});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wb_write_i = 0; wb_addr_i = 0; wb_data_i = 0;
        issue_i = 0; issue_rd_i = 0; issue_wr_i = 0; flush_i = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_i = 1; issue_wr_i = 1; issue_rd_i = rd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_write_i = 1; wb_addr_i = a; wb_data_i = d;
    endtask

    initial begin
        rst = 0; rs1_addr_i = 0; rs2_addr_i = 0;
        idle;
        repeat (2) tick;
        rs1_addr_i = 5;
        @(negedge clk);
        chk("reset data", rs1_data_o, 32'h0);
        chk("reset busy", {31'h0, rs1_busy_o}, 32'h0);
        tick;
        rst = 1;
        wb(5, 32'h12345678); issue(5);
        tick; idle;
        @(negedge clk);
        chk("x5 written", rs1_data_o, 32'h12345678);
        chk("x5 busy after set+wb", {31'h0, rs1_busy_o}, 32'h1);
        #2 rst = 0;
        #1;
        chk("async reset data", rs1_data_o, 32'h0);
        chk("async reset busy", {31'h0, rs1_busy_o}, 32'h0);
        tick; tick;
        rst = 1;
        @(negedge clk);
        chk("x5 after release", rs1_data_o, 32'h0);
        tick;
        rs1_addr_i = 0; wb(0, 32'hDEADBEEF);
        @(negedge clk);
        chk("x0 write cycle", rs1_data_o, 32'h0);
        tick; idle;
        @(negedge clk);
        chk("x0 after write", rs1_data_o, 32'h0);
        tick;
        rs2_addr_i = 7; wb(7, 32'hA5A5A5A5);
        tick; idle;
        @(negedge clk);
        chk("x7 next cycle", rs2_data_o, 32'hA5A5A5A5);
        rs1_addr_i = 7;
        #1;
        chk("dual read same index", rs1_data_o, rs2_data_o);
        chk("dual read rs1 value", rs1_data_o, 32'hA5A5A5A5);
        tick;
        wb(9, 32'h1);
        tick; idle; issue(9);
        tick; idle;
        rs1_addr_i = 9; wb(9, 32'h2);
        @(negedge clk);
        chk("bypass data", rs1_data_o, BYP ? 32'h2 : 32'h1);
        chk("bypass busy", {31'h0, rs1_busy_o}, BYP ? 32'h0 : 32'h1);
        tick; idle;
        @(negedge clk);
        chk("x9 after wb", rs1_data_o, 32'h2);
        chk("x9 busy after wb", {31'h0, rs1_busy_o}, 32'h0);
        tick;
        rs1_addr_i = 3; issue(3);
        tick; idle;
        @(negedge clk);
        chk("issue x3 busy", {31'h0, rs1_busy_o}, 32'h1);
        tick;
        issue(3); wb(3, 32'h33);
        tick; idle;
        @(negedge clk);
        chk("set beats clear", {31'h0, rs1_busy_o}, 32'h1);
        tick;
        wb(3, 32'h34);
        tick; idle;
        @(negedge clk);
        chk("wb clears x3", {31'h0, rs1_busy_o}, 32'h0);
        chk("x3 data", rs1_data_o, 32'h34);
        tick;
        issue(1); tick;
        issue(2); tick;
        issue(31); tick; idle;
        rs1_addr_i = 1; rs2_addr_i = 31;
        @(negedge clk);
        chk("x1 busy pre-flush", {31'h0, rs1_busy_o}, 32'h1);
        chk("x31 busy pre-flush", {31'h0, rs2_busy_o}, 32'h1);
        tick;
        flush_i = 1; issue(4);
        tick; idle;
        rs1_addr_i = 2; rs2_addr_i = 4;
        @(negedge clk);
        chk("flush x2", {31'h0, rs1_busy_o}, 32'h0);
        chk("flush beats issue x4", {31'h0, rs2_busy_o}, 32'h0);
        rs1_addr_i = 31; rs2_addr_i = 1;
        #1;
        chk("flush x31", {31'h0, rs1_busy_o}, 32'h0);
        chk("flush x1", {31'h0, rs2_busy_o}, 32'h0);
        tick; tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
